// File: rtl/cosim_commit_queue.sv
// Commit/trap queue between a multi-lane retire stage and a co-simulation checker.
// Valid lanes are packed in lane order, an optional trap entry follows them, and the head is read out combinationally.
module cosim_commit_queue #(
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter int unsigned XLEN         = 64,
    parameter int unsigned INST_BITS    = 32,
    parameter int unsigned RD           = 5,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [COMMIT_WIDTH-1:0]       in_valid,
    input  logic [XLEN*COMMIT_WIDTH-1:0]  in_pc,
    input  logic [INST_BITS*COMMIT_WIDTH-1:0] in_inst,
    input  logic [XLEN*COMMIT_WIDTH-1:0]  in_wdata,
    input  logic [XLEN*COMMIT_WIDTH-1:0]  in_mstatus,
    input  logic [COMMIT_WIDTH-1:0]       in_check,
    input  logic [COMMIT_WIDTH-1:0]       in_wdata_valid,
    input  logic [RD*COMMIT_WIDTH-1:0]    in_wdata_dest,
    input  logic [COMMIT_WIDTH-1:0]       in_wb,
    input  logic [RD*COMMIT_WIDTH-1:0]    in_wb_dest,
    input  logic                          int_xcpt,
    input  logic [XLEN-1:0]               cause,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_kind,
    output logic [XLEN-1:0]               out_pc,
    output logic [XLEN-1:0]               out_wdata,
    output logic [XLEN-1:0]               out_mstatus,
    output logic [INST_BITS-1:0]          out_inst,
    output logic                          out_check,
    output logic                          out_wdata_valid,
    output logic                          out_wb,
    output logic [RD-1:0]                 out_wdata_dest,
    output logic [RD-1:0]                 out_wb_dest,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] READY_C = CW'(COMMIT_WIDTH + 1);

    logic                 kind_q     [DEPTH];
    logic [XLEN-1:0]      pc_q       [DEPTH];
    logic [INST_BITS-1:0] inst_q     [DEPTH];
    logic [XLEN-1:0]      wdata_q    [DEPTH];
    logic [XLEN-1:0]      mstatus_q  [DEPTH];
    logic                 check_q    [DEPTH];
    logic                 wvalid_q   [DEPTH];
    logic [RD-1:0]        wdest_q    [DEPTH];
    logic                 wb_q       [DEPTH];
    logic [RD-1:0]        wbdest_q   [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic [CW-1:0] lane_off [COMMIT_WIDTH];
    logic [PW-1:0] lane_idx [COMMIT_WIDTH];
    logic [PW-1:0] trap_idx;
    logic [CW-1:0] n_commit;
    logic [CW-1:0] n_total;
    logic [CW-1:0] free;
    logic          fits;
    logic          enq;
    logic          deq;

    always_comb begin
        n_commit = '0;
        for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
            lane_off[i] = n_commit;
            lane_idx[i] = wptr_q + lane_off[i][PW-1:0];
            if (in_valid[i]) begin
                n_commit = n_commit + CW'(1);
            end
        end
        trap_idx = wptr_q + n_commit[PW-1:0];
        n_total  = n_commit + CW'(int_xcpt);
        // Free space ignores this cycle's dequeue, so a full queue drops even while draining.
        free     = DEPTH_C - count_q;
        fits     = (n_total <= free);
        enq      = fits && (n_total != '0);
        deq      = (count_q != '0) && out_ready;

        count_d    = count_q + (enq ? n_total : '0) - CW'(deq);
        wptr_d     = wptr_q + (enq ? n_total[PW-1:0] : '0);
        rptr_d     = rptr_q + PW'(deq);
        overflow_d = overflow_q | !fits;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage carries no reset; occupancy and pointers alone define validity.
    always_ff @(posedge clock) begin
        if (reset && enq) begin
            for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
                if (in_valid[i]) begin
                    kind_q[lane_idx[i]]    <= 1'b0;
                    pc_q[lane_idx[i]]      <= in_pc[i*XLEN +: XLEN];
                    inst_q[lane_idx[i]]    <= in_inst[i*INST_BITS +: INST_BITS];
                    wdata_q[lane_idx[i]]   <= in_wdata[i*XLEN +: XLEN];
                    mstatus_q[lane_idx[i]] <= in_mstatus[i*XLEN +: XLEN];
                    check_q[lane_idx[i]]   <= in_check[i];
                    wvalid_q[lane_idx[i]]  <= in_wdata_valid[i];
                    wdest_q[lane_idx[i]]   <= in_wdata_dest[i*RD +: RD];
                    wb_q[lane_idx[i]]      <= in_wb[i];
                    wbdest_q[lane_idx[i]]  <= in_wb_dest[i*RD +: RD];
                end
            end
            if (int_xcpt) begin
                kind_q[trap_idx]    <= 1'b1;
                pc_q[trap_idx]      <= '0;
                inst_q[trap_idx]    <= '0;
                wdata_q[trap_idx]   <= cause;
                mstatus_q[trap_idx] <= '0;
                check_q[trap_idx]   <= 1'b0;
                wvalid_q[trap_idx]  <= 1'b0;
                wdest_q[trap_idx]   <= '0;
                wb_q[trap_idx]      <= 1'b0;
                wbdest_q[trap_idx]  <= '0;
            end
        end
    end

    assign in_ready        = (free >= READY_C);
    assign out_valid       = (count_q != '0);
    assign out_kind        = kind_q[rptr_q];
    assign out_pc          = pc_q[rptr_q];
    assign out_inst        = inst_q[rptr_q];
    assign out_wdata       = wdata_q[rptr_q];
    assign out_mstatus     = mstatus_q[rptr_q];
    assign out_check       = check_q[rptr_q];
    assign out_wdata_valid = wvalid_q[rptr_q];
    assign out_wdata_dest  = wdest_q[rptr_q];
    assign out_wb          = wb_q[rptr_q];
    assign out_wb_dest     = wbdest_q[rptr_q];
    assign count           = count_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_cosim_commit_queue.sv
// Scoreboard bench for cosim_commit_queue: directed scenarios plus a long random run against a queue model.
module tb_cosim_commit_queue;

    localparam int DP = 8;

    typedef struct packed {
        logic        kind;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] wdata;
        logic [63:0] mstatus;
        logic        check;
        logic        wv;
        logic [4:0]  wd;
        logic        wb;
        logic [4:0]  wbd;
    } entry_t;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   in_valid;
    logic [127:0] in_pc, in_wdata, in_mstatus;
    logic [63:0]  in_inst;
    logic [1:0]   in_check, in_wdata_valid, in_wb;
    logic [9:0]   in_wdata_dest, in_wb_dest;
    logic         int_xcpt;
    logic [63:0]  cause;
    logic         in_ready, out_valid, out_ready, out_kind;
    logic [63:0]  out_pc, out_wdata, out_mstatus;
    logic [31:0]  out_inst;
    logic         out_check, out_wdata_valid, out_wb;
    logic [4:0]   out_wdata_dest, out_wb_dest;
    logic [3:0]   count;
    logic         overflow;

    entry_t       obs;
    entry_t       exp_q[$];
    bit           model_ovf;
    int unsigned  n_pass;
    int unsigned  n_total;

    cosim_commit_queue #(
        .COMMIT_WIDTH(2),
        .XLEN(64),
        .INST_BITS(32),
        .RD(5),
        .DEPTH(DP)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_wdata(in_wdata), .in_mstatus(in_mstatus), .in_check(in_check),
        .in_wdata_valid(in_wdata_valid), .in_wdata_dest(in_wdata_dest),
        .in_wb(in_wb), .in_wb_dest(in_wb_dest),
        .int_xcpt(int_xcpt), .cause(cause),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_pc(out_pc), .out_wdata(out_wdata),
        .out_mstatus(out_mstatus), .out_inst(out_inst), .out_check(out_check),
        .out_wdata_valid(out_wdata_valid), .out_wb(out_wb),
        .out_wdata_dest(out_wdata_dest), .out_wb_dest(out_wb_dest),
        .count(count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    assign obs = {out_kind, out_pc, out_inst, out_wdata, out_mstatus,
                  out_check, out_wdata_valid, out_wdata_dest, out_wb, out_wb_dest};

    task automatic clear_inputs();
        in_valid = '0; in_pc = '0; in_inst = '0; in_wdata = '0; in_mstatus = '0;
        in_check = '0; in_wdata_valid = '0; in_wdata_dest = '0; in_wb = '0;
        in_wb_dest = '0; int_xcpt = 1'b0; cause = '0;
    endtask

    task automatic rand_fields();
        in_pc          = {$urandom, $urandom, $urandom, $urandom};
        in_wdata       = {$urandom, $urandom, $urandom, $urandom};
        in_mstatus     = {$urandom, $urandom, $urandom, $urandom};
        in_inst        = {$urandom, $urandom};
        in_check       = 2'($urandom);
        in_wdata_valid = 2'($urandom);
        in_wb          = 2'($urandom);
        in_wdata_dest  = 10'($urandom);
        in_wb_dest     = 10'($urandom);
        cause          = {$urandom, $urandom};
    endtask

    // Advances one clock, applying the same inputs to the scoreboard model.
    task automatic tick();
        entry_t      e;
        int unsigned n;
        int unsigned free;
        bit          deq;
        if (!reset) begin
            exp_q.delete();
            model_ovf = 1'b0;
        end else begin
            deq  = (exp_q.size() != 0) && out_ready;
            n    = int'(in_valid[0]) + int'(in_valid[1]) + int'(int_xcpt);
            free = DP - exp_q.size();
            if (n > free) begin
                model_ovf = 1'b1;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (in_valid[i]) begin
                        e.kind    = 1'b0;
                        e.pc      = in_pc[i*64 +: 64];
                        e.inst    = in_inst[i*32 +: 32];
                        e.wdata   = in_wdata[i*64 +: 64];
                        e.mstatus = in_mstatus[i*64 +: 64];
                        e.check   = in_check[i];
                        e.wv      = in_wdata_valid[i];
                        e.wd      = in_wdata_dest[i*5 +: 5];
                        e.wb      = in_wb[i];
                        e.wbd     = in_wb_dest[i*5 +: 5];
                        exp_q.push_back(e);
                    end
                end
                if (int_xcpt) begin
                    e       = '0;
                    e.kind  = 1'b1;
                    e.wdata = cause;
                    exp_q.push_back(e);
                end
            end
            if (deq) void'(exp_q.pop_front());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        out_ready = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        n_total++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
    endtask

    task automatic test_two_lane();
        clear_inputs();
        rand_fields();
        in_valid = 2'b11;
        in_pc = {64'h1004, 64'h1000};
        out_ready = 1'b1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL two_lane_empty: out_valid got %b want 0", out_valid); else n_pass++;
        tick();
        clear_inputs();
        n_total++; if (count !== 4'd2) $display("FAIL two_lane_count2: got %0d want 2", count); else n_pass++;
        n_total++; if (out_pc !== 64'h1000) $display("FAIL two_lane_pc0: got %h want 1000", out_pc); else n_pass++;
        n_total++; if (out_valid !== 1'b1 || obs !== exp_q[0]) $display("FAIL two_lane_head0: got %h want %h", obs, exp_q[0]); else n_pass++;
        tick();
        n_total++; if (count !== 4'd1) $display("FAIL two_lane_count1: got %0d want 1", count); else n_pass++;
        n_total++; if (out_pc !== 64'h1004) $display("FAIL two_lane_pc1: got %h want 1004", out_pc); else n_pass++;
        n_total++; if (out_valid !== 1'b1 || obs !== exp_q[0]) $display("FAIL two_lane_head1: got %h want %h", obs, exp_q[0]); else n_pass++;
        tick();
        n_total++; if (count !== 4'd0 || out_valid !== 1'b0) $display("FAIL two_lane_drained: count %0d valid %b want 0 0", count, out_valid); else n_pass++;
    endtask

    task automatic test_trap();
        clear_inputs();
        rand_fields();
        in_valid = 2'b10;
        in_pc[127:64] = 64'h2000;
        int_xcpt = 1'b1;
        cause = 64'h8000000000000007;
        out_ready = 1'b0;
        tick();
        clear_inputs();
        n_total++; if (count !== 4'd2) $display("FAIL trap_count: got %0d want 2", count); else n_pass++;
        n_total++; if (out_kind !== 1'b0 || out_pc !== 64'h2000) $display("FAIL trap_first_commit: kind %b pc %h want 0 2000", out_kind, out_pc); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_total++; if (out_kind !== 1'b1 || out_wdata !== 64'h8000000000000007) $display("FAIL trap_entry: kind %b wdata %h want 1 8000000000000007", out_kind, out_wdata); else n_pass++;
        n_total++; if (out_valid !== 1'b1 || obs !== exp_q[0]) $display("FAIL trap_zero_fields: got %h want %h", obs, exp_q[0]); else n_pass++;
        tick();
        n_total++; if (count !== 4'd0) $display("FAIL trap_drained: got %0d want 0", count); else n_pass++;
    endtask

    task automatic test_overflow();
        clear_inputs();
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rand_fields();
            in_valid = 2'b11;
            tick();
        end
        n_total++; if (count !== 4'd8) $display("FAIL full_count: got %0d want 8", count); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL full_out_valid: got %b want 1", out_valid); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL full_no_overflow_yet: got %b want 0", overflow); else n_pass++;
        rand_fields();
        in_valid = 2'b11;
        tick();
        clear_inputs();
        n_total++; if (count !== 4'd8) $display("FAIL drop_count: got %0d want 8", count); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL drop_overflow: got %b want 1", overflow); else n_pass++;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_total++; if (out_valid !== 1'b1 || obs !== exp_q[0]) $display("FAIL drain_head%0d: got %h want %h", k, obs, exp_q[0]); else n_pass++;
            tick();
        end
        n_total++; if (count !== 4'd0 || overflow !== 1'b1) $display("FAIL drain_end: count %0d ovf %b want 0 1", count, overflow); else n_pass++;
    endtask

    task automatic test_wrap();
        clear_inputs();
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rand_fields();
            in_valid = (b == 3) ? 2'b01 : 2'b11;
            tick();
        end
        n_total++; if (count !== 4'd7) $display("FAIL wrap_fill: got %0d want 7", count); else n_pass++;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            rand_fields();
            in_valid = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_total++; if (out_valid !== 1'b1 || obs !== exp_q[0]) $display("FAIL wrap_head%0d: got %h want %h", k, obs, exp_q[0]); else n_pass++;
            tick();
            n_total++; if (count !== 4'd7) $display("FAIL wrap_count%0d: got %0d want 7", k, count); else n_pass++;
        end
        clear_inputs();
        for (int k = 0; k < 7; k++) begin
            n_total++; if (out_valid !== 1'b1 || obs !== exp_q[0]) $display("FAIL wrap_drain%0d: got %h want %h", k, obs, exp_q[0]); else n_pass++;
            tick();
        end
        n_total++; if (out_valid !== 1'b0) $display("FAIL wrap_empty: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_mid_reset();
        clear_inputs();
        out_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            rand_fields();
            in_valid = (b == 2) ? 2'b10 : 2'b11;
            tick();
        end
        n_total++; if (count !== 4'd5) $display("FAIL midrst_fill: got %0d want 5", count); else n_pass++;
        rand_fields();
        in_valid = 2'b11;
        int_xcpt = 1'b1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        clear_inputs();
        n_total++; if (count !== 4'd0) $display("FAIL midrst_count: got %0d want 0", count); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL midrst_overflow: got %b want 0", overflow); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b want 1", in_ready); else n_pass++;
        rand_fields();
        in_valid = 2'b01;
        tick();
        clear_inputs();
        n_total++; if (count !== 4'd1) $display("FAIL resume_count: got %0d want 1", count); else n_pass++;
        n_total++; if (out_valid !== 1'b1 || obs !== exp_q[0]) $display("FAIL resume_head: got %h want %h", obs, exp_q[0]); else n_pass++;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [6:0] st_got;
        logic [6:0] st_exp;
        int unsigned sz;
        for (int c = 0; c < 10000; c++) begin
            rand_fields();
            in_valid  = 2'($urandom_range(0, 3));
            int_xcpt  = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = !(c % 1000 == 999);
            sz        = exp_q.size();
            st_got = {count, out_valid, in_ready, overflow};
            st_exp = {4'(sz), sz != 0, (DP - sz) >= 3, model_ovf};
            n_total++; if (st_got !== st_exp) $display("FAIL rand_state@%0d: got %b want %b (count,valid,ready,ovf)", c, st_got, st_exp); else n_pass++;
            if (sz != 0) begin
                n_total++; if (obs !== exp_q[0]) $display("FAIL rand_head@%0d: got %h want %h", c, obs, exp_q[0]); else n_pass++;
            end
            tick();
        end
        reset = 1'b1;
        clear_inputs();
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        model_ovf = 1'b0;
        test_reset();
        test_two_lane();
        test_trap();
        test_overflow();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d passed", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/cosim_commit_queue.md
COSIM_COMMIT_QUEUE -- requirements
Module: cosim_commit_queue

Interface
REQ-001 SHALL have parameter COMMIT_WIDTH, default 2, number of commit lanes per cycle.
REQ-002 SHALL have parameter XLEN, default 64, PC/data/mstatus/cause width.
REQ-003 SHALL have parameter INST_BITS, default 32, instruction width.
REQ-004 SHALL have parameter RD, default 5, destination-register index width.
REQ-005 SHALL have parameter DEPTH, default 8, entry count; power of 2, >= COMMIT_WIDTH+1.
REQ-006 SHALL have ports, one per line:
clock  in  1  sole clock, rising edge.
reset  in  1  synchronous, active-low reset; 0 = reset.
in_valid  in  COMMIT_WIDTH  per-lane commit valid.
in_pc  in  XLEN*COMMIT_WIDTH  lane PCs, lane i at [(i+1)*XLEN-1 -: XLEN].
in_inst  in  INST_BITS*COMMIT_WIDTH  lane instructions.
in_wdata  in  XLEN*COMMIT_WIDTH  lane writeback data.
in_mstatus  in  XLEN*COMMIT_WIDTH  lane mstatus.
in_check  in  COMMIT_WIDTH  lane compare-enable.
in_wdata_valid  in  COMMIT_WIDTH  lane wdata valid.
in_wdata_dest  in  RD*COMMIT_WIDTH  lane wdata destination.
in_wb  in  COMMIT_WIDTH  lane instruction writes back.
in_wb_dest  in  RD*COMMIT_WIDTH  lane writeback destination.
int_xcpt  in  1  interrupt/trap raised this cycle.
cause  in  XLEN  trap cause.
in_ready  out  1  free entries >= COMMIT_WIDTH+1.
out_valid  out  1  head entry available.
out_ready  in  1  consumer accepts head.
out_kind  out  1  0 = commit, 1 = trap.
out_pc, out_wdata, out_mstatus  out  XLEN each  head fields; out_wdata carries cause for trap.
out_inst  out  INST_BITS  head instruction.
out_check, out_wdata_valid, out_wb  out  1 each  head flags.
out_wdata_dest, out_wb_dest  out  RD each  head destinations.
count  out  clog2(DEPTH)+1  current occupancy.
overflow  out  1  sticky drop indicator.

Function
REQ-007 SHALL, per cycle, enqueue N = popcount(in_valid) + int_xcpt entries when free space >= N.
REQ-008 SHALL compact valid lanes in ascending lane order; lane 0 (if valid) enqueues first, no gaps.
REQ-009 SHALL enqueue the trap entry (kind=1, wdata=cause, other fields 0) after all same-cycle commit entries.
REQ-010 SHALL dequeue the head when out_valid && out_ready; out_* reflect the head combinationally from storage.
REQ-011 SHALL make enqueued entries visible at out_* the cycle after enqueue (1-cycle latency; no fall-through).
REQ-012 SHALL update count = count + N(accepted) - deq each cycle; simultaneous enqueue/dequeue allowed at any occupancy.
REQ-013 SHALL compute free space for REQ-007 as DEPTH - count (current-cycle dequeue not credited).
REQ-014 SHALL, when N > free space, drop all N same-cycle entries (no partial enqueue) and set overflow=1.
REQ-015 SHALL hold overflow at 1 until reset.
REQ-016 SHALL wrap read/write pointers modulo DEPTH.
REQ-017 SHALL hold out_valid=0 when count=0; out_* fields are don't-care when out_valid=0.
REQ-018 SHALL ignore in_* lane fields whose in_valid bit is 0.

Reset
REQ-019 SHALL, while reset=0 at a rising edge, clear pointers, count=0, overflow=0, out_valid=0, in_ready=1.
REQ-020 SHALL, on reset asserted mid-operation, discard all stored entries and ignore same-cycle inputs.
REQ-021 SHALL resume normal enqueue on the first edge with reset=1.

Verification
REQ-022 Two lanes valid (pc 0x1000, 0x1004), out_ready=1 -> next cycle out_pc=0x1000, then 0x1004; count 2,1,0.
REQ-023 in_valid=2'b10 (pc 0x2000) + int_xcpt, cause=0x8000000000000007 -> entries commit 0x2000 then kind=1, out_wdata=cause.
REQ-024 out_ready=0, DEPTH=8, enqueue 2/cycle 4 cycles -> count=8, in_ready=0, out_valid=1; 5th burst dropped, overflow=1, count stays 8.
REQ-025 count=7, 1 lane valid, out_ready=1 same cycle -> count stays 7; full pointer wrap after 9 entries preserves order.
REQ-026 count=5, reset=0 one cycle with lanes valid -> count=0, out_valid=0, overflow=0, in_ready=1.
REQ-027 Random lane masks/traps/out_ready for 10k cycles vs. reference queue model -> identical output stream, overflow only when N > free.
